// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: single-cycle 32x32 multiply and a 33-cycle
// restoring radix-2 divider (32 RUN steps plus one FIX cycle for sign correction).
module mul_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] quot_reg;
  logic [31:0] rem_reg;
  logic [31:0] divisor_reg;
  logic        sign_q_reg;
  logic        sign_r_reg;

  logic        accept;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] q_final;
  logic [31:0] r_final;

  assign busy   = (state_reg != IDLE);
  assign hi     = hi_reg;
  assign lo     = lo_reg;
  assign accept = in_valid & ~busy & ~flush & resetn;

  assign a_ext         = $signed({{32{rs_data[31]}}, rs_data});
  assign b_ext         = $signed({{32{rt_data[31]}}, rt_data});
  assign prod_signed   = a_ext * b_ext;
  assign prod_unsigned = {32'd0, rs_data} * {32'd0, rt_data};

  assign abs_a = rs_data[31] ? -rs_data : rs_data;
  assign abs_b = rt_data[31] ? -rt_data : rt_data;

  // Restoring step: the dividend shifts out of quot_reg MSB-first into the
  // partial remainder while quotient bits shift in at the bottom.
  always_comb begin
    shifted   = {rem_reg, quot_reg[31]};
    trial     = shifted - {1'b0, divisor_reg};
    rem_next  = shifted[31:0];
    quot_next = {quot_reg[30:0], 1'b0};
    if (!trial[32]) begin
      rem_next  = trial[31:0];
      quot_next = {quot_reg[30:0], 1'b1};
    end
  end

  assign q_final = sign_q_reg ? -quot_reg : quot_reg;
  assign r_final = sign_r_reg ? -rem_reg  : rem_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 6'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      quot_reg    <= 32'd0;
      rem_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
    end else if (flush) begin
      // Abort without touching HI/LO; in IDLE this simply blocks acceptance.
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_div) begin
              quot_reg    <= abs_a;
              divisor_reg <= abs_b;
              rem_reg     <= 32'd0;
              sign_q_reg  <= rs_data[31] ^ rt_data[31];
              sign_r_reg  <= rs_data[31];
              cnt_reg     <= 6'd0;
              state_reg   <= RUN;
            end else if (is_divu) begin
              quot_reg    <= rs_data;
              divisor_reg <= rt_data;
              rem_reg     <= 32'd0;
              sign_q_reg  <= 1'b0;
              sign_r_reg  <= 1'b0;
              cnt_reg     <= 6'd0;
              state_reg   <= RUN;
            end else if (is_mult) begin
              hi_reg <= prod_signed[63:32];
              lo_reg <= prod_signed[31:0];
            end else if (is_multu) begin
              hi_reg <= prod_unsigned[63:32];
              lo_reg <= prod_unsigned[31:0];
            end else if (hi_wen) begin
              hi_reg <= rs_data;
            end else if (lo_wen) begin
              lo_reg <= rs_data;
            end
          end
        end
        RUN: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next;
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          lo_reg    <= q_final;
          hi_reg    <= r_final;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
